// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the 4:1 stream multiplexer and its arbiter.
package stream_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Channel after k, wrapping modulo NUM_CH through the natural 2-bit overflow.
  function automatic sel_t next_ch(input sel_t k);
    return k + sel_t'(1);
  endfunction

endpackage

// File: rtl/stream_mux4_if.sv
// Handshake bundle for stream_mux4: four producer channels in, one consumer channel out.
// With STREAM_MUX4_LOCK_EN defined the bundle also carries in_last/out_last.
interface stream_mux4_if #(
  parameter int DATA_W = 8
);
  import stream_mux_pkg::*;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  sel_t                     out_sel;
  logic                     out_ready;
`ifdef STREAM_MUX4_LOCK_EN
  logic [NUM_CH-1:0]        in_last;
  logic                     out_last;
`endif

  // The mux is the slave side; producers plus consumer together form the master side.
  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef STREAM_MUX4_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef STREAM_MUX4_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: the first requester at or after ptr wins.
module rr_arb4
  import stream_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] gnt,
  output sel_t              idx
);

  sel_t w_cand;
  logic w_found;

  always_comb begin
    gnt     = '0;
    idx     = ptr;
    w_cand  = ptr;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = ptr + sel_t'(i);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/stream_mux4.sv
// 4:1 round-robin stream mux with a one-deep registered output stage tagged by source channel.
// Optional packet lock (arbitration held until in_last) is enabled by STREAM_MUX4_LOCK_EN.
module stream_mux4
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  stream_mux4_if.slave bus
);

  logic              r_out_valid_p1;
  logic [DATA_W-1:0] r_out_data_p1;
  sel_t              r_out_sel_p1;
  sel_t              r_rr_ptr;

  logic              w_load_ok;
  logic              w_fire;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt;
  logic [NUM_CH-1:0] w_in_ready;
  sel_t              w_idx;
  logic [DATA_W-1:0] w_data;

`ifdef STREAM_MUX4_LOCK_EN
  logic              r_locked;
  sel_t              r_lock_ch;
  logic              r_out_last_p1;
  logic [NUM_CH-1:0] w_lock_mask;
  logic              w_last;

  // While locked only the owning channel may request, so others stall even if it idles.
  assign w_lock_mask = {{(NUM_CH-1){1'b0}}, 1'b1} << r_lock_ch;
  assign w_req       = r_locked ? (bus.in_valid & w_lock_mask) : bus.in_valid;
  assign w_last      = bus.in_last[w_idx];
`else
  assign w_req       = bus.in_valid;
`endif

  rr_arb4 u_arb (
    .req (w_req),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign w_load_ok  = !r_out_valid_p1 || bus.out_ready;
  // rst_n gates ready so no producer sees a handshake while reset is held.
  assign w_in_ready = w_gnt & {NUM_CH{w_load_ok & rst_n}};
  assign w_fire     = |w_in_ready;
  assign w_data     = bus.in_data[w_idx*DATA_W +: DATA_W];

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid_p1 <= 1'b0;
      r_out_data_p1  <= '0;
      r_out_sel_p1   <= '0;
      r_rr_ptr       <= '0;
`ifdef STREAM_MUX4_LOCK_EN
      r_out_last_p1  <= 1'b0;
      r_locked       <= 1'b0;
      r_lock_ch      <= '0;
`endif
    end else if (w_fire) begin
      r_out_valid_p1 <= 1'b1;
      r_out_data_p1  <= w_data;
      r_out_sel_p1   <= w_idx;
`ifdef STREAM_MUX4_LOCK_EN
      r_out_last_p1  <= w_last;
      if (w_last) begin
        r_locked <= 1'b0;
        r_rr_ptr <= next_ch(w_idx);
      end else begin
        r_locked  <= 1'b1;
        r_lock_ch <= w_idx;
      end
`else
      r_rr_ptr       <= next_ch(w_idx);
`endif
    end else if (bus.out_ready) begin
      r_out_valid_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid_p1;
  assign bus.out_data  = r_out_data_p1;
  assign bus.out_sel   = r_out_sel_p1;
`ifdef STREAM_MUX4_LOCK_EN
  assign bus.out_last  = r_out_last_p1;
`endif

endmodule
